// File: rtl/fixed_div_if.sv
// Operand/result handshake bundle for the signed fixed-point divider.
// The master side is the upstream/downstream pair; the slave side is the divider.
interface fixed_div_if #(
    parameter int W = 16
);
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_num;
    logic [W-1:0] i_den;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_quot;
    logic         o_div0;
    logic         o_sat;

    modport master (
        output i_valid, i_num, i_den, i_ready,
        input  o_ready, o_valid, o_quot, o_div0, o_sat
    );

    modport slave (
        input  i_valid, i_num, i_den, i_ready,
        output o_ready, o_valid, o_quot, o_div0, o_sat
    );
endinterface

// File: rtl/fixed_div.sv
// Signed Q(W-N).N restoring divider, fixed W+N+1 edges from accept to o_valid.
// Accepts only in IDLE; the result is held in DONE until i_ready completes the handshake.
module fixed_div #(
    parameter int W = 16,
    parameter int N = 10
) (
    input  logic       clk,
    input  logic       rst,
    fixed_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int ITER = W + N;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0]   LAST = CW'(ITER);
    localparam logic [W-1:0]    MAXW = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]    MINP = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [ITER-1:0] MAXQ = {{(N+1){1'b0}}, {(W-1){1'b1}}};

    state_t          state, state_nxt;
    logic            ready, valid;
    logic [CW-1:0]   cnt;
    logic            sign, num_neg, div0;
    logic [W-1:0]    den_mag, rem;
    logic [ITER-1:0] dvd, quo;
    logic [W-1:0]    quot_q;
    logic            div0_q, sat_q;

    logic [W-1:0]    num_mag_in, den_mag_in;
    logic [W:0]      rem_shift;
    logic [W-1:0]    diff;
    logic            ge;
    logic            fin;
    logic            q_sat;
    logic [W-1:0]    q_mag, q_signed;

    // W-bit negation keeps the most negative input as magnitude 2^(W-1).
    assign num_mag_in = bus.i_num[W-1] ? (~bus.i_num + W'(1)) : bus.i_num;
    assign den_mag_in = bus.i_den[W-1] ? (~bus.i_den + W'(1)) : bus.i_den;

    // One restoring step: the partial remainder stays below den_mag, so the
    // low W bits of the difference are exact whenever the trial succeeds.
    assign rem_shift = {rem, dvd[ITER-1]};
    assign ge        = (rem_shift >= {1'b0, den_mag});
    assign diff      = rem_shift[W-1:0] - den_mag;
    assign fin       = (cnt == LAST);

    assign q_sat    = (quo > MAXQ);
    assign q_mag    = q_sat ? MAXW : quo[W-1:0];
    assign q_signed = sign ? (~q_mag + W'(1)) : q_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        valid     = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.i_valid) state_nxt = CALC;
            end
            CALC: begin
                if (fin) state_nxt = DONE;
            end
            DONE: begin
                valid = 1'b1;
                if (bus.i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            sign    <= 1'b0;
            num_neg <= 1'b0;
            div0    <= 1'b0;
            den_mag <= '0;
            rem     <= '0;
            dvd     <= '0;
            quo     <= '0;
            quot_q  <= '0;
            div0_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        sign    <= bus.i_num[W-1] ^ bus.i_den[W-1];
                        num_neg <= bus.i_num[W-1];
                        div0    <= (bus.i_den == '0);
                        den_mag <= den_mag_in;
                        dvd     <= {num_mag_in, {N{1'b0}}};
                        quo     <= '0;
                        rem     <= '0;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    if (!fin) begin
                        dvd <= {dvd[ITER-2:0], 1'b0};
                        quo <= {quo[ITER-2:0], ge};
                        rem <= ge ? diff : rem_shift[W-1:0];
                        cnt <= cnt + CW'(1);
                    end else if (div0) begin
                        // Zero divisor reports full-scale in the dividend's direction.
                        quot_q <= num_neg ? MINP : MAXW;
                        div0_q <= 1'b1;
                        sat_q  <= 1'b1;
                    end else begin
                        quot_q <= q_signed;
                        div0_q <= 1'b0;
                        sat_q  <= q_sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = valid;
    assign bus.o_quot  = quot_q;
    assign bus.o_div0  = div0_q;
    assign bus.o_sat   = sat_q;
endmodule

// File: tb/tb_fixed_div.sv
// Directed bench for fixed_div at W=16, N=10 with hand-computed quotients.
module tb_fixed_div;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fixed_div_if #(.W(16)) bus ();
    fixed_div #(.W(16), .N(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] num;
        logic [15:0] den;
        logic [15:0] quot;
        logic        div0;
        logic        sat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] num, input logic [15:0] den);
        bus.i_num   = num;
        bus.i_den   = den;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit scramble, output int edges);
        edges = 0;
        while (!bus.o_valid && edges < 100) begin
            if (scramble) begin
                bus.i_valid = 1'b1;
                bus.i_num   = 16'($urandom);
                bus.i_den   = 16'($urandom);
            end
            tick();
            edges++;
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic release_result();
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_num = 16'h1234;
        bus.i_den = 16'h0100;
        bus.i_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_quot !== 16'h0000) begin n_err++; $display("FAIL reset_quot: got %h want 0000", bus.o_quot); end
        n_cmp++; if (bus.o_div0 !== 1'b0) begin n_err++; $display("FAIL reset_div0: got %b want 0", bus.o_div0); end
        n_cmp++; if (bus.o_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %b want 0", bus.o_sat); end
        bus.i_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int e;
        accept(16'h0C00, 16'h0600);
        wait_valid(1'b0, e);
        n_cmp++; if (e != 27) begin n_err++; $display("FAIL basic_latency: got %0d want 27", e); end
        n_cmp++; if (bus.o_quot !== 16'h0800) begin n_err++; $display("FAIL basic_quot: got %h want 0800", bus.o_quot); end
        n_cmp++; if (bus.o_div0 !== 1'b0) begin n_err++; $display("FAIL basic_div0: got %b want 0", bus.o_div0); end
        n_cmp++; if (bus.o_sat !== 1'b0) begin n_err++; $display("FAIL basic_sat: got %b want 0", bus.o_sat); end
        release_result();
    endtask

    task automatic test_vectors();
        vec_t v[$];
        int e;
        v.push_back('{16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b0});
        v.push_back('{16'hF800, 16'h0200, 16'hF000, 1'b0, 1'b0});
        v.push_back('{16'h8000, 16'hFC00, 16'h7FFF, 1'b0, 1'b1});
        v.push_back('{16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1});
        v.push_back('{16'h8000, 16'h0001, 16'h8001, 1'b0, 1'b1});
        v.push_back('{16'hF400, 16'h0600, 16'hF800, 1'b0, 1'b0});
        v.push_back('{16'h0400, 16'h0000, 16'h7FFF, 1'b1, 1'b1});
        v.push_back('{16'hFC00, 16'h0000, 16'h8001, 1'b1, 1'b1});
        foreach (v[i]) begin
            accept(v[i].num, v[i].den);
            wait_valid(1'b0, e);
            n_cmp++; if (e != 27) begin n_err++; $display("FAIL vec%0d_latency: got %0d want 27", i, e); end
            n_cmp++; if (bus.o_quot !== v[i].quot) begin n_err++; $display("FAIL vec%0d_quot: %h/%h got %h want %h", i, v[i].num, v[i].den, bus.o_quot, v[i].quot); end
            n_cmp++; if (bus.o_div0 !== v[i].div0) begin n_err++; $display("FAIL vec%0d_div0: got %b want %b", i, bus.o_div0, v[i].div0); end
            n_cmp++; if (bus.o_sat !== v[i].sat) begin n_err++; $display("FAIL vec%0d_sat: got %b want %b", i, bus.o_sat, v[i].sat); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int e;
        accept(16'h0C00, 16'h0600);
        wait_valid(1'b1, e);
        n_cmp++; if (e != 27) begin n_err++; $display("FAIL bp_latency: got %0d want 27", e); end
        n_cmp++; if (bus.o_quot !== 16'h0800) begin n_err++; $display("FAIL bp_quot_scrambled: got %h want 0800", bus.o_quot); end
        for (int c = 0; c < 10; c++) begin
            bus.i_valid = c[0];
            bus.i_num   = 16'($urandom);
            bus.i_den   = 16'($urandom);
            tick();
            n_cmp++;
            if ({bus.o_valid, bus.o_ready, bus.o_quot} !== {1'b1, 1'b0, 16'h0800}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b r=%b q=%h want v=1 r=0 q=0800", c, bus.o_valid, bus.o_ready, bus.o_quot);
            end
        end
        bus.i_valid = 1'b0;
        release_result();
        n_cmp++; if ({bus.o_ready, bus.o_valid} !== 2'b10) begin n_err++; $display("FAIL bp_idle: got r=%b v=%b want r=1 v=0", bus.o_ready, bus.o_valid); end
        accept(16'h0400, 16'h0C00);
        wait_valid(1'b0, e);
        n_cmp++; if (bus.o_quot !== 16'h0155) begin n_err++; $display("FAIL bp_second_quot: got %h want 0155", bus.o_quot); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int e;
        bus.i_ready = 1'b1;
        accept(16'h0200, 16'h0400);
        wait_valid(1'b0, e);
        n_cmp++; if (bus.o_quot !== 16'h0200) begin n_err++; $display("FAIL b2b_first_quot: got %h want 0200", bus.o_quot); end
        bus.i_num   = 16'hF400;
        bus.i_den   = 16'h0600;
        bus.i_valid = 1'b1;
        tick();
        n_cmp++; if ({bus.o_ready, bus.o_valid} !== 2'b10) begin n_err++; $display("FAIL b2b_handshake: got r=%b v=%b want r=1 v=0", bus.o_ready, bus.o_valid); end
        tick();
        bus.i_valid = 1'b0;
        n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL b2b_reaccept: got r=%b want 0", bus.o_ready); end
        wait_valid(1'b0, e);
        n_cmp++; if (e != 27) begin n_err++; $display("FAIL b2b_latency: got %0d want 27", e); end
        n_cmp++; if (bus.o_quot !== 16'hF800) begin n_err++; $display("FAIL b2b_second_quot: got %h want F800", bus.o_quot); end
        tick();
        bus.i_ready = 1'b0;
    endtask

    task automatic test_abort();
        int e;
        int seen_valid;
        accept(16'h0C00, 16'h0600);
        for (int c = 0; c < 12; c++) tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.o_ready, bus.o_valid, bus.o_quot, bus.o_div0, bus.o_sat} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL abort_outputs: got r=%b v=%b q=%h d=%b s=%b want r=1 v=0 q=0000 d=0 s=0",
                     bus.o_ready, bus.o_valid, bus.o_quot, bus.o_div0, bus.o_sat);
        end
        seen_valid = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.o_valid) seen_valid++;
        end
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.o_valid) seen_valid++;
        end
        n_cmp++; if (seen_valid != 0) begin n_err++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen_valid); end
        accept(16'h0F00, 16'h0300);
        wait_valid(1'b0, e);
        n_cmp++; if (e != 27) begin n_err++; $display("FAIL abort_next_latency: got %0d want 27", e); end
        n_cmp++; if (bus.o_quot !== 16'h1400) begin n_err++; $display("FAIL abort_next_quot: got %h want 1400", bus.o_quot); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fixed_div.md
FIXED_DIV -- requirements
Module: fixed_div

Interface
REQ-001 The module SHALL have parameter W, default 16, total word width of operands and result.
REQ-002 The module SHALL have parameter N, default 10, fractional bit count (Q(W-N).N, signed two's complement).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_valid  input  1  upstream operand pair valid.
REQ-006 o_ready  output  1  block can accept an operand pair.
REQ-007 i_num  input  W  dividend, signed Q(W-N).N.
REQ-008 i_den  input  W  divisor, signed Q(W-N).N.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  downstream accepts result.
REQ-011 o_quot  output  W  quotient, signed Q(W-N).N.
REQ-012 o_div0  output  1  result was produced from a zero divisor.
REQ-013 o_sat  output  1  result magnitude was clipped.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; o_ready=1 only in IDLE, o_valid=1 only in DONE.
REQ-015 Accept: IDLE and i_valid=1 at a rising edge -> capture sign = i_num[W-1] XOR i_den[W-1], |i_num|, |i_den|, and the zero-divisor flag; go to CALC with iteration counter = 0.
REQ-016 Magnitudes SHALL be formed as W-bit unsigned two's-complement negations, so the most negative input (e.g. 0x8000) yields magnitude 2^(W-1) without error.
REQ-017 CALC SHALL run restoring unsigned division of (|num| << N), a W+N-bit value, by |den|, producing one quotient bit per cycle MSB-first for exactly W+N cycles (26 at defaults).
REQ-018 After the last iteration, a single finalize cycle SHALL register o_quot/o_div0/o_sat and enter DONE; accept-edge to o_valid rise SHALL be W+N+1 edges (27 at defaults), independent of operand values.
REQ-019 Quotient magnitude SHALL be truncated (rounded toward zero).
REQ-020 If the unsigned quotient exceeds 2^(W-1)-1, the magnitude SHALL become 2^(W-1)-1 (0x7FFF) and o_sat=1; otherwise o_sat=0.
REQ-021 o_quot SHALL equal the magnitude if sign=0, else its two's-complement negation; the result range is symmetric: 0x8000 is never produced.
REQ-022 Zero divisor: the iterations still run (fixed latency); result SHALL be 0x7FFF if i_num[W-1]=0, else 0x8001, with o_div0=1, o_sat=1.
REQ-023 DONE: o_quot, o_div0 and o_sat SHALL hold stable while o_valid=1 and i_ready=0; on o_valid and i_ready both 1 at an edge -> IDLE.
REQ-024 No new operands SHALL be accepted in CALC or DONE; i_valid there is ignored, and i_num/i_den changes there do not affect the result.
REQ-025 The minimum accept-to-accept interval SHALL be W+N+3 cycles (accept, W+N iterations, finalize, handshake; re-accept in IDLE the next cycle).

Reset
REQ-026 While rst=1, the FSM SHALL be IDLE, o_ready=1, o_valid=0, o_quot=0, o_div0=0, o_sat=0, and iteration counter and datapath registers zero.
REQ-027 rst asserted during CALC or DONE SHALL immediately abort the operation with no result emitted; after release the block SHALL accept the next operand pair normally.

Verification
REQ-028 0x0C00 / 0x0600 (3.0/1.5) -> o_quot=0x0800, o_div0=0, o_sat=0, o_valid rises exactly 27 edges after accept.
REQ-029 0x0400 / 0x0C00 (1/3) -> 0x0155 (truncated); 0xF800 / 0x0200 (-2.0/0.5) -> 0xF000 (-4.0); 0x8000 / 0xFC00 (-32/-1) -> 0x7FFF, o_sat=1.
REQ-030 0x7FFF / 0x0001 -> 0x7FFF, o_sat=1; 0x8000 / 0x0001 -> 0x8001, o_sat=1.
REQ-031 0x0400 / 0x0000 -> 0x7FFF with o_div0=1; 0xFC00 / 0x0000 -> 0x8001 with o_div0=1; both have 27-edge latency.
REQ-032 Hold i_ready=0 for 10 cycles in DONE while toggling i_valid/i_num -> o_quot stable, o_ready=0; then i_ready=1 -> IDLE, back-to-back second operation completes correctly.
REQ-033 Assert rst at iteration 12 of CALC -> all outputs at reset values, no o_valid; the next operation after release gives the correct result.
